// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM encoding, requester IDs
// and register width.
package reg_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WSET    = 2'd1,
        WSTROBE = 2'd2,
        READ    = 2'd3
    } state_e;

    localparam logic REQ_H = 1'b0;
    localparam logic REQ_I = 1'b1;

    localparam int REG_W = 16;

endpackage

// File: rtl/reg_addr_decode.sv
// Address decode for the register bank: one-hot enable and read-slice select,
// both zero for addresses at or beyond NUM_REGS.
module reg_addr_decode
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [REG_W*NUM_REGS-1:0] rd_bus_i,
    output logic [NUM_REGS-1:0]       onehot_o,
    output logic [REG_W-1:0]          rd_data_o
);

    always_comb begin
        onehot_o  = '0;
        rd_data_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_i == ADDR_W'(k)) begin
                onehot_o[k] = 1'b1;
                rd_data_o   = rd_bus_i[REG_W*k +: REG_W];
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-port (host / internal engine) sequencer for a falling-edge-strobed register bank.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise host has fixed priority.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      HReq,
    input  logic                      HWr,
    input  logic [ADDR_W-1:0]         HAddr,
    input  logic [REG_W-1:0]          HWrData,
    output logic                      HAck,
    output logic [REG_W-1:0]          HRdData,
    input  logic                      IReq,
    input  logic                      IWr,
    input  logic [ADDR_W-1:0]         IAddr,
    input  logic [REG_W-1:0]          IWrData,
    output logic                      IAck,
    output logic [REG_W-1:0]          IRdData,
    output logic [NUM_REGS-1:0]       RegEn,
    output logic                      RegWr,
    output logic [REG_W-1:0]          RegWrData,
    input  logic [REG_W*NUM_REGS-1:0] RegRdBus,
    output logic                      Busy
);

    state_e              state_q;
    logic                owner_q;
    logic                hack_q;
    logic                iack_q;
    logic                regwr_q;
    logic                busy_q;
    logic [NUM_REGS-1:0] regen_q;
    logic [REG_W-1:0]    wrdata_q;
    logic [REG_W-1:0]    hrd_q;
    logic [REG_W-1:0]    ird_q;

    logic                grant_d;
    logic                grant_wr_d;
    logic [ADDR_W-1:0]   grant_addr_d;
    logic [REG_W-1:0]    grant_data_d;
    logic [NUM_REGS-1:0] dec_en;
    logic [REG_W-1:0]    dec_rd;

`ifdef ARB_ROUND_ROBIN_EN
    logic                rr_q;

    // On a tie the pointer names the winner; a lone requester always wins.
    always_comb begin
        grant_d = (HReq && IReq) ? rr_q : (IReq ? REQ_I : REQ_H);
    end
`else
    always_comb begin
        grant_d = HReq ? REQ_H : REQ_I;
    end
`endif

    assign grant_wr_d   = (grant_d == REQ_H) ? HWr     : IWr;
    assign grant_addr_d = (grant_d == REQ_H) ? HAddr   : IAddr;
    assign grant_data_d = (grant_d == REQ_H) ? HWrData : IWrData;

    reg_addr_decode #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_decode (
        .addr_i    (grant_addr_d),
        .rd_bus_i  (RegRdBus),
        .onehot_o  (dec_en),
        .rd_data_o (dec_rd)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            owner_q  <= REQ_H;
            hack_q   <= 1'b0;
            iack_q   <= 1'b0;
            regwr_q  <= 1'b0;
            busy_q   <= 1'b0;
            regen_q  <= '0;
            wrdata_q <= '0;
            hrd_q    <= '0;
            ird_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q     <= REQ_H;
`endif
        end else begin
            hack_q <= 1'b0;
            iack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (HReq || IReq) begin
                        owner_q <= grant_d;
                        busy_q  <= 1'b1;
                        if (grant_wr_d) begin
                            state_q  <= WSET;
                            regen_q  <= dec_en;
                            wrdata_q <= grant_data_d;
                            regwr_q  <= 1'b1;
                        end else begin
                            // Reads complete at the grant edge: data and ack land together.
                            state_q <= READ;
                            if (grant_d == REQ_H) begin
                                hrd_q  <= dec_rd;
                                hack_q <= 1'b1;
                            end else begin
                                ird_q  <= dec_rd;
                                iack_q <= 1'b1;
                            end
`ifdef ARB_ROUND_ROBIN_EN
                            rr_q <= ~grant_d;
`endif
                        end
                    end
                end
                WSET: begin
                    // Dropping the strobe here is the edge the bank latches on.
                    state_q <= WSTROBE;
                    regwr_q <= 1'b0;
                    hack_q  <= (owner_q == REQ_H);
                    iack_q  <= (owner_q == REQ_I);
`ifdef ARB_ROUND_ROBIN_EN
                    rr_q    <= ~owner_q;
`endif
                end
                WSTROBE: begin
                    state_q <= IDLE;
                    regen_q <= '0;
                    busy_q  <= 1'b0;
                end
                READ: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign HAck      = hack_q;
    assign IAck      = iack_q;
    assign HRdData   = hrd_q;
    assign IRdData   = ird_q;
    assign RegEn     = regen_q;
    assign RegWr     = regwr_q;
    assign RegWrData = wrdata_q;
    assign Busy      = busy_q;

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Sequences and shares a bank of NUM_REGS 16-bit Register16-style registers between two requesters: host bus port (H) and internal engine port (I).
- The registers latch on the falling edge of their write strobe when enabled. This block generates the strobe, a one-hot register enable and write data, and muxes read data back.
- Sits between the host bus interface / internal sequencer and the register bank.

Parameters:
- NUM_REGS, 8, number of registers in the bank (2..16).
- ADDR_W, 3, address width; 2^ADDR_W >= NUM_REGS.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- HReq  in  1  host request.
- HWr  in  1  host direction: 1 = write, 0 = read.
- HAddr  in  ADDR_W  host register address.
- HWrData  in  16  host write data.
- HAck  out  1  host completion, one-cycle pulse.
- HRdData  out  16  host read data, valid while HAck = 1 and held until the next host read completes.
- IReq, IWr, IAddr, IWrData, IAck, IRdData: same as the H ports, for the internal requester.
- RegEn  out  NUM_REGS  one-hot register enable.
- RegWr  out  1  bank write strobe; registers latch on its falling edge.
- RegWrData  out  16  bank write data.
- RegRdBus  in  16*NUM_REGS  concatenated register outputs; register k occupies bits [16k+15:16k].
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: HAck, IAck, RegWr and Busy = 0; RegEn and RegWrData = 0; HRdData and IRdData = 0; state = IDLE; round-robin pointer = H.
- Handshake rules:
  - A requester holds Req, Wr, Addr and WrData stable until it sees Ack.
  - Ack is a single-cycle pulse.
  - If Req is still high in the cycle after Ack, it is treated as a new request.
- Arbitration is performed only in IDLE. Fixed priority: H wins over I.
- The winner's Wr, Addr and WrData are registered at the grant edge; inputs are ignored afterwards.
- FSM states: IDLE, WSET, WSTROBE, READ.
  - IDLE: on grant, go to WSET (write) or READ (read).
  - WSET, entered at the grant edge:
    - RegEn = decode(addr) and RegWrData = data, driven from registers.
    - RegWr = 1.
    - Next state is always WSTROBE.
  - WSTROBE:
    - RegWr = 0. The falling edge of RegWr latches the register.
    - RegEn and RegWrData are held through this state.
    - The winner's Ack = 1. Next state is IDLE.
  - IDLE after a write: RegEn returns to 0; RegWrData is held.
  - READ:
    - Captures RegRdBus slice[addr] into the winner's RdData and asserts that Ack.
    - Next state is IDLE.
- Latency from grant edge to Ack:
  - Write: Ack is high during the 2nd cycle.
  - Read: Ack is high during the 1st cycle.
  - Minimum request spacing: write 3 cycles, read 2 cycles.
- Out-of-range addresses (addr >= NUM_REGS):
  - Write: performs the full sequence with RegEn = 0, so no register changes; Ack is still given.
  - Read: returns 0x0000 with Ack.
- Simultaneous HReq and IReq in IDLE: H is granted; I is served on its next IDLE arbitration.
- Back-to-back H requests can starve I; this is acceptable without the optional feature.
- Only one Ack is asserted per transaction, never both.
- Reset asserted mid-transaction forces all outputs to their reset values immediately.
  - If reset hits in WSET, RegWr falls asynchronously while RegEn is cleared. Because RegEn is cleared, the in-flight write must not commit.
  - The pending requester is not acked and must re-issue.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Two-entry round-robin pointer, updated at each Ack to point at the non-served requester.
  - On a tie, the pointer's requester wins.
  - Guarantees I is served within one transaction of H.
- ARB_ROUND_ROBIN_EN undefined: fixed H-over-I priority, and no pointer flop is generated.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE = 2'd0, WSET = 2'd1, WSTROBE = 2'd2, READ = 2'd3.
  - Requester IDs: REQ_H = 1'b0, REQ_I = 1'b1.
  - Register-width constant REG_W = 16.
- One sub-module, reg_addr_decode:
  - Maps ADDR_W address to NUM_REGS one-hot, zero when out of range.
  - Selects the read slice, zero when out of range.

Test Plan:
- Single H write: addr 2, data 0xA5C3 → RegWr high 1 cycle; RegEn = 0x04 during WSET/WSTROBE; HAck during WSTROBE; model register 2 = 0xA5C3; no IAck.
- I read: addr 5 with RegRdBus slice 5 = 0x1234 → IAck 1 cycle after grant; IRdData = 0x1234 and held after IAck; HAck stays 0.
- Simultaneous HReq write addr 1 and IReq read addr 1, held asserted:
  - Fixed priority: H acked first, then I reads the new value.
  - With ARB_ROUND_ROBIN_EN, after a prior H transaction: I is granted first.
- Out of range, NUM_REGS = 6: write addr 7 → RegEn = 0 throughout, HAck given, all registers unchanged; read addr 6 → HRdData = 0x0000.
- Reset pulse during WSET → outputs zero the same cycle; target register keeps its old value; no Ack; reissued request completes normally.
- Continuous HReq writes with IReq held:
  - Fixed priority: IAck never occurs over 10 transactions.
  - Round-robin: Acks alternate H, I, H, I.
